// File: rtl/load_store_unit.sv
// Memory stage: data-memory handshake, store lane steering and load extension.
// Faulting accesses never reach memory and retire as a one-cycle fault packet.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_alu_result,
    input  logic [31:0]       ex_rs2_data,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              fault_misaligned,
    output logic              fault_illegal,
    output logic [ADDR_W-1:0] fault_addr
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        accept, is_mem, f3_ok, illegal, misaligned, go_mem;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [2:0]  cap_f3;
    logic [1:0]  cap_off;
    logic        cap_rw;

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_mem_read || ex_mem_write;
    assign go_mem   = is_mem && !illegal && !misaligned;

    always_comb begin
        f3_ok = 1'b0;
        if (ex_mem_read)
            f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (ex_mem_write)
            f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010};
    end

    assign illegal = (ex_mem_read && ex_mem_write) || (is_mem && !f3_ok);
    assign misaligned = is_mem && !illegal &&
        ((ex_funct3[1:0] == 2'b01 && ex_alu_result[0]) ||
         (ex_funct3[1:0] == 2'b10 && ex_alu_result[1:0] != 2'b00));

    always_comb begin
        st_wdata = ex_rs2_data;
        st_wstrb = 4'b1111;
        case (ex_funct3[1:0])
            2'b00: begin
                st_wdata = {4{ex_rs2_data[7:0]}};
                st_wstrb = 4'b0001 << ex_alu_result[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_rs2_data[15:0]}};
                st_wstrb = 4'b0011 << {ex_alu_result[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Extraction uses the lane and size captured at accept time.
    assign ld_byte = mem_rdata[{cap_off, 3'b000} +: 8];
    assign ld_half = cap_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = mem_rdata;
        case (cap_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && go_mem) state_d = WAIT;
            WAIT: if (mem_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_wstrb        <= '0;
            wb_valid         <= 1'b0;
            wb_reg_write     <= 1'b0;
            wb_rd            <= '0;
            wb_data          <= '0;
            fault_misaligned <= 1'b0;
            fault_illegal    <= 1'b0;
            fault_addr       <= '0;
            cap_f3           <= '0;
            cap_off          <= '0;
            cap_rw           <= 1'b0;
        end else begin
            wb_valid         <= 1'b0;
            fault_misaligned <= 1'b0;
            fault_illegal    <= 1'b0;
            if (state_q == IDLE && accept) begin
                wb_rd <= ex_rd;
                if (illegal || misaligned) begin
                    wb_valid         <= 1'b1;
                    wb_reg_write     <= 1'b0;
                    fault_illegal    <= illegal;
                    fault_misaligned <= misaligned;
                    fault_addr       <= ex_alu_result;
                end else if (is_mem) begin
                    mem_req   <= 1'b1;
                    mem_we    <= ex_mem_write;
                    mem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                    mem_wdata <= ex_mem_write ? st_wdata : 32'b0;
                    mem_wstrb <= ex_mem_write ? st_wstrb : 4'b0000;
                    cap_f3    <= ex_funct3;
                    cap_off   <= ex_alu_result[1:0];
                    cap_rw    <= ex_reg_write;
                end else begin
                    wb_valid     <= 1'b1;
                    wb_data      <= ex_alu_result;
                    wb_reg_write <= ex_reg_write;
                end
            end else if (state_q == WAIT && mem_ready) begin
                mem_req  <= 1'b0;
                wb_valid <= 1'b1;
                if (mem_we) begin
                    wb_reg_write <= 1'b0;
                    wb_data      <= 32'b0;
                end else begin
                    wb_reg_write <= cap_rw;
                    wb_data      <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault_misaligned;
    logic        fault_illegal;
    logic [31:0] fault_addr;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .fault_misaligned(fault_misaligned),
        .fault_illegal(fault_illegal), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One instruction through the stage; memory answers after nwait stall cycles.
    task automatic run_op(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic rw,
                          input int nwait, input logic [31:0] rdata);
        logic        ill, mis, memop;
        int unsigned size, off, reqcnt, guard;
        logic [31:0] v, exp_wdata, exp_data;
        logic [3:0]  exp_strb;

        ill = (mr && mw) ||
              (mr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
              (mw && !(f3 inside {3'd0, 3'd1, 3'd2}));
        size = 1 << f3[1:0];
        off = alu % 4;
        mis = (mr || mw) && !ill && (alu % size != 0);
        memop = (mr || mw) && !ill && !mis;

        if (size == 1) exp_wdata = (rs2 & 32'hFF) * 32'h0101_0101;
        else if (size == 2) exp_wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
        else exp_wdata = rs2;
        exp_strb = 4'(((1 << size) - 1) << off);

        v = rdata >> (8 * off);
        if (size == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32768) v = v - 65536;
        end
        exp_data = mw ? 32'h0 : v;

        @(negedge clk);
        chk("wb_pulse_end", {31'b0, wb_valid}, 32'h0);
        ex_valid = 1'b1;
        ex_mem_read = mr;
        ex_mem_write = mw;
        ex_funct3 = f3;
        ex_alu_result = alu;
        ex_rs2_data = rs2;
        ex_rd = rd;
        ex_reg_write = rw;
        guard = 0;
        while (!ex_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("ex_ready_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(negedge clk);
        if (!memop) begin
            chk("wb_valid", {31'b0, wb_valid}, 32'h1);
            chk("mem_req_idle", {31'b0, mem_req}, 32'h0);
            chk("flt_ill", {31'b0, fault_illegal}, {31'b0, ill});
            chk("flt_mis", {31'b0, fault_misaligned}, {31'b0, mis});
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, rd});
            if (ill || mis) begin
                chk("flt_addr", fault_addr, alu);
                chk("wb_rw_flt", {31'b0, wb_reg_write}, 32'h0);
            end else begin
                chk("wb_data_alu", wb_data, alu);
                chk("wb_rw", {31'b0, wb_reg_write}, {31'b0, rw});
            end
        end else begin
            chk("mem_req", {31'b0, mem_req}, 32'h1);
            chk("ex_ready_wait", {31'b0, ex_ready}, 32'h0);
            chk("mem_addr", mem_addr, alu & 32'hFFFF_FFFC);
            chk("mem_we", {31'b0, mem_we}, {31'b0, mw});
            chk("mem_wstrb", {28'b0, mem_wstrb}, mw ? {28'b0, exp_strb} : 32'h0);
            if (mw) chk("mem_wdata", mem_wdata, exp_wdata);
            reqcnt = 1;
            repeat (nwait) begin
                mem_ready = 1'b0;
                @(negedge clk);
                if (mem_req) reqcnt++;
                chk("addr_hold", mem_addr, alu & 32'hFFFF_FFFC);
            end
            mem_ready = 1'b1;
            mem_rdata = rdata;
            @(posedge clk);
            #1 mem_ready = 1'b0;
            mem_rdata = $urandom;
            @(negedge clk);
            chk("req_cycles", reqcnt, nwait + 1);
            chk("wb_valid_mem", {31'b0, wb_valid}, 32'h1);
            chk("mem_req_done", {31'b0, mem_req}, 32'h0);
            chk("ex_ready_done", {31'b0, ex_ready}, 32'h1);
            chk("wb_data_mem", wb_data, exp_data);
            chk("wb_rw_mem", {31'b0, wb_reg_write}, {31'b0, rw && !mw});
        end
    endtask

    initial begin
        int kind;
        logic [31:0] a;
        logic [31:0] exp_rdy [4];
        logic [31:0] exp_wbv [4];
        exp_rdy = '{32'h0, 32'h1, 32'h0, 32'h1};
        exp_wbv = '{32'h0, 32'h1, 32'h0, 32'h1};

        rst = 1'b1;
        ex_valid = 1'b0;
        ex_alu_result = '0;
        ex_rs2_data = '0;
        ex_funct3 = '0;
        ex_mem_read = 1'b0;
        ex_mem_write = 1'b0;
        ex_reg_write = 1'b0;
        ex_rd = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_wbv", {31'b0, wb_valid}, 32'h0);
        chk("rst_rdy", {31'b0, ex_ready}, 32'h1);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_strb", {28'b0, mem_wstrb}, 32'h0);
        chk("rst_wbdata", wb_data, 32'h0);
        chk("rst_faddr", fault_addr, 32'h0);
        chk("rst_flt", {30'b0, fault_illegal, fault_misaligned}, 32'h0);
        rst = 1'b0;

        run_op(0, 0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 32'h0);
        run_op(0, 1, 3'd0, 32'h0000_0103, 32'hAABB_CCDD, 5'd1, 1, 2, 32'h0);
        run_op(1, 0, 3'd0, 32'h0000_0202, 32'h0, 5'd3, 1, 1, 32'h1280_FF7F);
        run_op(1, 0, 3'd4, 32'h0000_0202, 32'h0, 5'd3, 1, 0, 32'h1280_FF7F);
        run_op(1, 0, 3'd5, 32'h0000_0202, 32'h0, 5'd3, 1, 0, 32'h1280_FF7F);
        run_op(1, 0, 3'd2, 32'h0000_0006, 32'h0, 5'd4, 1, 0, 32'h0);
        run_op(1, 0, 3'd3, 32'h0000_0040, 32'h0, 5'd4, 1, 0, 32'h0);
        run_op(1, 1, 3'd2, 32'h0000_0040, 32'h0, 5'd4, 1, 0, 32'h0);

        // Held loads with an always-ready memory, then a non-memory op.
        @(negedge clk);
        ex_valid = 1'b1;
        ex_mem_read = 1'b1;
        ex_mem_write = 1'b0;
        ex_funct3 = 3'd2;
        ex_alu_result = 32'h0000_0300;
        ex_rd = 5'd7;
        ex_reg_write = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_rdy", {31'b0, ex_ready}, exp_rdy[i]);
            chk("b2b_wbv", {31'b0, wb_valid}, exp_wbv[i]);
            if (wb_valid) chk("b2b_data", wb_data, 32'hCAFE_F00D);
        end
        ex_mem_read = 1'b0;
        ex_alu_result = 32'h0000_55AA;
        ex_rd = 5'd9;
        mem_ready = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("b2b_alu_wbv", {31'b0, wb_valid}, 32'h1);
        chk("b2b_alu_data", wb_data, 32'h0000_55AA);
        chk("b2b_alu_rd", {27'b0, wb_rd}, 32'd9);
        chk("b2b_alu_req", {31'b0, mem_req}, 32'h0);

        // Reset while a load is outstanding.
        @(negedge clk);
        ex_valid = 1'b1;
        ex_mem_read = 1'b1;
        ex_funct3 = 3'd2;
        ex_alu_result = 32'h0000_0400;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rw_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_req0", {31'b0, mem_req}, 32'h0);
        chk("rw_wbv", {31'b0, wb_valid}, 32'h0);
        chk("rw_rdy", {31'b0, ex_ready}, 32'h1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("late_rdy_wbv", {31'b0, wb_valid}, 32'h0);
        @(negedge clk);
        chk("late_rdy_wbv2", {31'b0, wb_valid}, 32'h0);
        chk("late_rdy_req", {31'b0, mem_req}, 32'h0);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op(kind inside {[3:5], 9}, kind inside {[6:9]},
                   3'($urandom_range(0, 7)), a, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
